// File: rtl/bist_pkg.sv
// Shared types, default constants and the LFSR next-state function for the BIST controller.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]  DEF_POLY   = 8'hB8;
    localparam int unsigned DEF_SEED_A = 1;
    localparam int unsigned DEF_SEED_B = 0;

    // Widest register lfsr_next can handle; callers cast in and out of this width.
    localparam int unsigned LFSR_MAX_W = 64;

    // De Bruijn step: taps selected by poly, plus the NOR of the low bits so that
    // the all-zero state is visited and the period is a full 2**width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    width
    );
        logic                  fb;
        logic                  low_any;
        logic [LFSR_MAX_W-1:0] nxt;
        fb      = 1'b0;
        low_any = 1'b0;
        nxt     = '0;
        for (int i = 0; i < int'(LFSR_MAX_W); i++) begin
            if (i < width) begin
                fb = fb ^ (cur[i] & poly[i]);
            end
            if (i < width - 1) begin
                low_any = low_any | cur[i];
            end
        end
        for (int i = 1; i < int'(LFSR_MAX_W); i++) begin
            if (i < width) begin
                nxt[i] = cur[i-1];
            end
        end
        nxt[0] = fb ^ ~low_any;
        return nxt;
    endfunction

endpackage

// File: rtl/bist_lfsr_gen.sv
// Operand pattern generator: loadable de Bruijn LFSR stepping on request.
module bist_lfsr_gen
    import bist_pkg::*;
#(
    parameter int unsigned        DATA_W = 8,
    parameter logic [DATA_W-1:0]  POLY   = DATA_W'(DEF_POLY),
    parameter logic [DATA_W-1:0]  SEED   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] q
);

    // Seed on reset/load, otherwise advance one step when asked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= DATA_W'(lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(POLY), int'(DATA_W)));
        end
    end

endmodule

// File: rtl/bist_lfsr_ctrl.sv
// BIST controller for the ALU datapath: drives LFSR operands, compares the DUT
// response against a golden ROM and reports pass/fail, fail count and first
// failing address. Define BIST_MISR_EN to add response signature compaction.
module bist_lfsr_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       SEL_W     = 4,
    parameter int unsigned       PAT_COUNT = 256,
    parameter logic [DATA_W-1:0] POLY      = DATA_W'(DEF_POLY),
    parameter logic [DATA_W-1:0] SEED_A    = DATA_W'(DEF_SEED_A),
    parameter logic [DATA_W-1:0] SEED_B    = DATA_W'(DEF_SEED_B),
    parameter int unsigned       ADDR_W    = (PAT_COUNT > 1) ? $clog2(PAT_COUNT) : 1,
    parameter int unsigned       CNT_W     = $clog2(PAT_COUNT + 1)
`ifdef BIST_MISR_EN
    ,
    parameter logic [DATA_W:0]   GOLDEN_SIG = '0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sel_cfg,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    output logic [SEL_W-1:0]  dut_sel,
    input  logic [DATA_W:0]   dut_resp,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W:0]   rom_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail_addr
`ifdef BIST_MISR_EN
    ,
    output logic [DATA_W:0]   signature
`endif
);

    localparam int unsigned RESP_W = DATA_W + 1;

    state_t state;
    state_t state_next;
    logic   load_c;
    logic   step_c;
    logic   clr_c;
    logic   cmp_c;
    logic   last_c;
    logic   mismatch_c;
    logic   inc_c;
    logic   fail_zero_c;
    logic   pass_c;

    assign last_c      = (rom_addr == ADDR_W'(PAT_COUNT - 1));
    assign mismatch_c  = cmp_c && (dut_resp != rom_data);
    assign inc_c       = mismatch_c && (fail_count != '1);
    assign fail_zero_c = (fail_count == '0) && !mismatch_c;

    bist_lfsr_gen #(.DATA_W(DATA_W), .POLY(POLY), .SEED(SEED_A)) u_gen_a (
        .clk   (clk),
        .reset (reset),
        .load  (load_c),
        .step  (step_c),
        .q     (dut_a)
    );

    bist_lfsr_gen #(.DATA_W(DATA_W), .POLY(POLY), .SEED(SEED_B)) u_gen_b (
        .clk   (clk),
        .reset (reset),
        .load  (load_c),
        .step  (step_c),
        .q     (dut_b)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle controls; abort beats start beats last compare.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        clr_c      = 1'b0;
        cmp_c      = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && start) begin
                    state_next = RUN;
                    load_c     = 1'b1;
                    clr_c      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    clr_c      = 1'b1;
                end else begin
                    cmp_c  = 1'b1;
                    step_c = 1'b1;
                    if (last_c) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_next = IDLE;
                    clr_c      = 1'b1;
                end else if (start) begin
                    state_next = RUN;
                    load_c     = 1'b1;
                    clr_c      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BIST_MISR_EN
    // Signature register shares the LFSR rule, one bit wider with the taps shifted up.
    localparam logic [DATA_W:0] MISR_POLY = {POLY, 1'b0};

    logic [DATA_W:0] sig_step_c;
    logic [DATA_W:0] sig_next_c;

    assign sig_step_c = RESP_W'(lfsr_next(LFSR_MAX_W'(signature), LFSR_MAX_W'(MISR_POLY),
                                          int'(RESP_W))) ^ dut_resp;
    assign sig_next_c = cmp_c ? sig_step_c : signature;
    assign pass_c     = fail_zero_c && (sig_next_c == GOLDEN_SIG);

    // Compact every compared response; cleared when a run starts or is abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signature <= '0;
        end else if (clr_c) begin
            signature <= '0;
        end else if (cmp_c) begin
            signature <= sig_step_c;
        end
    end
`else
    assign pass_c = fail_zero_c;
`endif

    // Status flags, ROM address, op-select latch and mismatch bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            dut_sel         <= '0;
            rom_addr        <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            pass <= (state_next == DONE) && pass_c;
            if (load_c) begin
                dut_sel <= sel_cfg;
            end
            if (clr_c) begin
                rom_addr        <= '0;
                fail_count      <= '0;
                first_fail_addr <= '0;
            end else begin
                if (step_c) begin
                    rom_addr <= last_c ? '0 : rom_addr + ADDR_W'(1);
                end
                if (inc_c) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
                if (mismatch_c && (fail_count == '0)) begin
                    first_fail_addr <= rom_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_lfsr_ctrl.sv
// Scoreboard bench for bist_lfsr_ctrl: stimulus queues expected operand words and
// run results, a monitor pops and compares whenever the controller presents them.
module tb_bist_lfsr_ctrl;

    localparam int unsigned PC = 256;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] addr;
        logic [3:0] sel;
    } op_t;

    typedef struct {
        logic       pass;
        logic [8:0] fcnt;
        logic [7:0] ffa;
        logic [7:0] a_end;
        logic [8:0] sig;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] sel_cfg = 4'd0;
    logic [7:0] dut_a;
    logic [7:0] dut_b;
    logic [3:0] dut_sel;
    logic [8:0] dut_resp;
    logic [7:0] rom_addr;
    logic [8:0] rom_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] fail_count;
    logic [7:0] first_fail_addr;

    logic [8:0] rom     [PC];
    logic [8:0] rom_xor [PC];

    op_t  op_q[$];
    res_t res_q[$];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Reference 8-bit de Bruijn step (taps 7,5,4,3 plus zero insertion).
    function automatic logic [7:0] m_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[6:0] == 7'd0);
        return {s[6:0], fb};
    endfunction

    // Reference ALU: response is {result, carry}.
    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel);
        logic [8:0] t;
        case (sel)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {1'b0, a & b};
            4'd3:    t = {1'b0, a ^ b};
            default: t = {1'b0, a | b};
        endcase
        return {t[7:0], t[8]};
    endfunction

`ifdef BIST_MISR_EN
    function automatic logic [8:0] misr_step(input logic [8:0] s, input logic [8:0] d);
        logic fb;
        fb = s[8] ^ s[6] ^ s[5] ^ s[4] ^ (s[7:0] == 8'd0);
        return {s[7:0], fb} ^ d;
    endfunction

    function automatic logic [8:0] gold_sig();
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        a = 8'h01;
        b = 8'h00;
        s = 9'd0;
        for (int k = 0; k < 256; k++) begin
            s = misr_step(s, alu(a, b, 4'd0));
            a = m_step(a);
            b = m_step(b);
        end
        return s;
    endfunction

    localparam logic [8:0] GOLD = gold_sig();
    logic [8:0] signature;
`endif

    assign dut_resp = alu(dut_a, dut_b, dut_sel);
    assign rom_data = rom[rom_addr] ^ rom_xor[rom_addr];

`ifdef BIST_MISR_EN
    bist_lfsr_ctrl #(.DATA_W(8), .SEL_W(4), .PAT_COUNT(PC), .GOLDEN_SIG(GOLD)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .sel_cfg         (sel_cfg),
        .dut_a           (dut_a),
        .dut_b           (dut_b),
        .dut_sel         (dut_sel),
        .dut_resp        (dut_resp),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .signature       (signature)
    );
`else
    bist_lfsr_ctrl #(.DATA_W(8), .SEL_W(4), .PAT_COUNT(PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .sel_cfg         (sel_cfg),
        .dut_a           (dut_a),
        .dut_b           (dut_b),
        .dut_sel         (dut_sel),
        .dut_resp        (dut_resp),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_fcnt"},  32'(fail_count), 32'd0);
        check({tag, "_ffa"},   32'(first_fail_addr), 32'd0);
        check({tag, "_a"},     32'(dut_a), 32'h01);
        check({tag, "_b"},     32'(dut_b), 32'h00);
        check({tag, "_sel"},   32'(dut_sel), 32'd0);
        check({tag, "_addr"},  32'(rom_addr), 32'd0);
    endtask

    task automatic clear_corrupt();
        for (int k = 0; k < int'(PC); k++) rom_xor[k] = 9'd0;
    endtask

    // Build the golden ROM and expectations for one run, then pulse start.
    task automatic launch(input logic [3:0] sel, input bit expect_done);
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        op_t        o;
        res_t       r;
        a      = 8'h01;
        b      = 8'h00;
        s      = 9'd0;
        r.fcnt = 9'd0;
        r.ffa  = 8'd0;
        for (int k = 0; k < int'(PC); k++) begin
            rom[k] = alu(a, b, sel);
            o.a    = a;
            o.b    = b;
            o.addr = 8'(k);
            o.sel  = sel;
            op_q.push_back(o);
            if (rom_xor[k] != 9'd0) begin
                if (r.fcnt == 9'd0) r.ffa = 8'(k);
                r.fcnt = r.fcnt + 9'd1;
            end
`ifdef BIST_MISR_EN
            s = misr_step(s, alu(a, b, sel));
`endif
            a = m_step(a);
            b = m_step(b);
        end
        r.a_end = a;
        r.sig   = s;
        r.pass  = (r.fcnt == 9'd0);
`ifdef BIST_MISR_EN
        r.pass  = r.pass && (s == GOLD);
`endif
        if (expect_done) res_q.push_back(r);
        sel_cfg = sel;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        sel_cfg = ~sel;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
        end
    endtask

    // Monitor: operand stream every busy cycle, run results on each done rise.
    initial begin : monitor
        logic busy_prev;
        logic done_prev;
        int   run_cycles;
        op_t  e;
        res_t r;
        busy_prev  = 1'b0;
        done_prev  = 1'b0;
        run_cycles = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) run_cycles = 0;
            if (busy) begin
                run_cycles++;
                if (op_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL op_underflow: busy cycle %0d with no expected operands", run_cycles);
                end else begin
                    e = op_q.pop_front();
                    check("operands", 32'({dut_a, dut_b, rom_addr, dut_sel}), 32'(e));
                end
            end
            if (done && !done_prev) begin
                if (res_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: done rose with no run expected");
                end else begin
                    r = res_q.pop_front();
                    check("fail_count",      32'(fail_count), 32'(r.fcnt));
                    check("first_fail_addr", 32'(first_fail_addr), 32'(r.ffa));
                    check("pass",            32'(pass), 32'(r.pass));
                    check("a_after_run",     32'(dut_a), 32'(r.a_end));
                    check("addr_wrap",       32'(rom_addr), 32'd0);
                    check("run_length",      32'(run_cycles), 32'(PC));
                    check("busy_in_done",    32'(busy), 32'd0);
`ifdef BIST_MISR_EN
                    check("signature",       32'(signature), 32'(r.sig));
`endif
                end
            end
            busy_prev = busy;
            done_prev = done;
        end
    end

    initial begin : stim
        bit saw_done;
        clear_corrupt();
        for (int k = 0; k < int'(PC); k++) rom[k] = 9'd0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;
        @(negedge clk);

        // Clean add run: must pass with the A LFSR back at its seed.
        launch(4'd0, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_pass", 32'(pass), 32'd1);
        check("hold_a",    32'(dut_a), 32'h01);

        // Fresh run from DONE with two corrupted ROM words.
        rom_xor[5]   = 9'h001;
        rom_xor[200] = 9'h100;
        launch(4'd1, 1'b1);
        wait_done();

        // Mismatch on the final address; a start mid-run is ignored.
        clear_corrupt();
        rom_xor[255] = 9'h080;
        launch(4'd2, 1'b1);
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Abort in RUN cycle 10 clears results; then a full run from IDLE.
        clear_corrupt();
        rom_xor[3] = 9'h002;
        launch(4'd3, 1'b0);
        repeat (9) @(negedge clk);
        check("fail_before_abort", 32'(fail_count), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_fcnt", 32'(fail_count), 32'd0);
        check("abort_ffa",  32'(first_fail_addr), 32'd0);
        op_q.delete();
        launch(4'd3, 1'b1);
        wait_done();

        // Reset in RUN cycle 100: immediate reset values, no done afterwards.
        clear_corrupt();
        launch(4'd5, 1'b0);
        repeat (99) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset("midrun_reset");
        op_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'd0);
        check("idle_busy",           32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bist_lfsr_ctrl.md
Name: bist_lfsr_ctrl

Overview:
Parametrised BIST controller for the ALU datapath. It generates two complete-sequence (de Bruijn) LFSR operand streams and drives the DUT operand and op-select inputs. Each cycle it compares the DUT response {result, carry} against a golden ROM word and reports pass/fail, the fail count and the first failing address. It sits between the pattern sources, the ALU under test and the golden ROM, and replaces the free-running, always-on compare scheme with a start/done controlled run.

Parameters:
DATA_W, 8, operand width; DUT response width is DATA_W+1.
SEL_W, 4, op-select width passed through to the DUT.
PAT_COUNT, 256, patterns per run; legal range 1..2**DATA_W.
POLY, 8'hB8, LFSR tap mask, bit i set means state[i] feeds back (default = x^8+x^6+x^5+x^4+1).
SEED_A, 1, operand A LFSR seed.
SEED_B, 0, operand B LFSR seed.
ADDR_W, $clog2(PAT_COUNT), ROM address width (minimum 1).
CNT_W, $clog2(PAT_COUNT+1), fail counter width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a run from IDLE or DONE
abort  in  1  pulse; terminates a run and returns to IDLE
sel_cfg  in  SEL_W  op-select, sampled on start and held for the whole run
dut_a  out  DATA_W  operand A to DUT
dut_b  out  DATA_W  operand B to DUT
dut_sel  out  SEL_W  op-select to DUT
dut_resp  in  DATA_W+1  DUT response {result, carry}, combinational from dut_a/dut_b/dut_sel
rom_addr  out  ADDR_W  golden ROM address
rom_data  in  DATA_W+1  golden word, combinational read
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid while done: fail_count==0 (and signature match if the optional feature is enabled)
fail_count  out  CNT_W  mismatches in the current/last run, saturating
first_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none

Behaviour:
- Reset: state=IDLE. dut_a=SEED_A, dut_b=SEED_B, dut_sel=0, rom_addr=0, busy=0, done=0, pass=0, fail_count=0, first_fail_addr=0.
- LFSR step: fb = XOR(state & POLY) ^ NOR(state[DATA_W-2:0]); next = {state[DATA_W-2:0], fb}.
  - Period is exactly 2**DATA_W and includes all-zero, so there is no lockup.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN. On entry: load seeds, latch dut_sel=sel_cfg, rom_addr=0, clear fail_count, first_fail_addr and the fail flag.
  - RUN, every cycle: compare dut_resp vs rom_data at the clock edge (pattern k is paired with address k; zero extra latency). Then step both LFSRs and increment rom_addr.
  - RUN --compare of address PAT_COUNT-1--> DONE. Exactly PAT_COUNT compares per run.
  - RUN --abort--> IDLE. Results are cleared; no compare happens on the abort cycle.
  - DONE: outputs held. start -> RUN (fresh run). abort -> IDLE.
- Priority within one cycle: abort over start over last-compare. start in RUN is ignored.
- Mismatch handling: fail_count increments, saturating at 2**CNT_W-1. first_fail_addr is written only on the first mismatch of a run.
- Compares happen only in RUN. dut_* outputs hold their values in IDLE/DONE.
- rom_addr wraps to 0 on the transition to DONE.
- Reset asserted mid-run: immediate return to reset values. No done pulse is produced.

Optional Feature:
Macro BIST_MISR_EN.
- Defined:
  - Adds parameter GOLDEN_SIG (DATA_W+1 bits, default 0) and output signature (DATA_W+1).
  - A MISR with the same feedback rule as the LFSRs, widened by one bit with POLY extended, compacts dut_resp on every RUN cycle. It is cleared to 0 on run start.
  - pass = (fail_count==0) && (signature==GOLDEN_SIG).
- Not defined: no signature port; pass depends on fail_count only.

Decomposition:
- Shared package bist_pkg: state enum (IDLE/RUN/DONE), default POLY and seed constants, and a function lfsr_next(state, poly) used by both generators and the MISR.
- One sub-module, bist_lfsr_gen (DATA_W, POLY, SEED; ports clk, reset, load, step, q), instantiated twice for A and B.

Test Plan:
- Reset, then one start with defaults -> cycle 1 of RUN has dut_a=8'h01, dut_b=8'h00; next cycle dut_a=8'h02, dut_b=8'h01.
- Full run with a ROM produced from the reference ALU model for sel_cfg=4'b0000 -> done after exactly 256 RUN cycles, pass=1, fail_count=0; the A LFSR returns to 8'h01 after 256 steps.
- ROM corrupted at addresses 5 and 200 -> fail_count=2, first_fail_addr=5, pass=0.
- abort at RUN cycle 10 -> IDLE next cycle, busy=0, done=0, fail_count=0; a following start runs a full 256 patterns.
- reset asserted at RUN cycle 100 -> all outputs at reset values in the same cycle, no done.
- BIST_MISR_EN defined, GOLDEN_SIG set to the model signature -> pass=1; flip one ROM-matching DUT bit via force -> pass=0 and the signature differs.
